// File: rtl/radix_digit_serializer.sv
// radix_digit_serializer: converts a VALUE_W-bit unsigned value into base-N
// digits (N = 2..15) by repeated division, one digit per valid/ready beat.
// Default build emits least-significant digit first.
// Optional macro RADIX_SERIALIZER_MSB_FIRST_EN: buffer all digits, then emit
// most-significant digit first.

// Combinational unsigned divider: VALUE_W-bit dividend by DIGIT_W-bit divisor.
module radix_divider #(
  parameter int VALUE_W = 32,
  parameter int DIGIT_W = 4
) (
  input  logic [VALUE_W-1:0] dividend,
  input  logic [DIGIT_W-1:0] divisor,
  output logic [VALUE_W-1:0] quotient,
  output logic [DIGIT_W-1:0] remainder,
  output logic               err
);

  logic [DIGIT_W:0] part;

  // Restoring long division, one quotient bit per dividend bit.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' so each loop step sees the
    // previous step's partial remainder; clocked state always uses '<='.
    part     = '0;
    quotient = '0;
    for (int i = VALUE_W - 1; i >= 0; i--) begin
      part = {part[DIGIT_W-1:0], dividend[i]};
      if (part >= {1'b0, divisor}) begin
        part        = part - {1'b0, divisor};
        quotient[i] = 1'b1;
      end
    end
    remainder = part[DIGIT_W-1:0];
  end

  assign err = (divisor == '0);

endmodule

module radix_digit_serializer #(
  parameter int VALUE_W    = 32,
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  input  logic [DIGIT_W-1:0] in_base,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic               out_last,
  output logic               out_err
);

  localparam int CNT_W = $clog2(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, DIVIDE, EMIT, ERR} state_t;

  state_t             state, state_nxt;
  logic [VALUE_W-1:0] cur;
  logic [VALUE_W-1:0] quo;
  logic [DIGIT_W-1:0] base;
  logic [DIGIT_W-1:0] rem;
  logic               div_err;
  logic [CNT_W-1:0]   count;

  radix_divider #(.VALUE_W(VALUE_W), .DIGIT_W(DIGIT_W)) u_div (
    .dividend (cur),
    .divisor  (base),
    .quotient (quo),
    .remainder(rem),
    .err      (div_err)
  );

  assign in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:   if (in_valid) state_nxt = (in_base < DIGIT_W'(2)) ? ERR : DIVIDE;
`ifdef RADIX_SERIALIZER_MSB_FIRST_EN
      DIVIDE: if (quo == '0) state_nxt = EMIT;
      EMIT:   if (out_ready && out_last) state_nxt = IDLE;
`else
      DIVIDE: state_nxt = EMIT;
      EMIT:   if (out_ready) state_nxt = out_last ? IDLE : DIVIDE;
`endif
      ERR:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RADIX_SERIALIZER_MSB_FIRST_EN
  logic [DIGIT_W-1:0] digit_buf [MAX_DIGITS];

  // Digit stack: each intermediate remainder is pushed at index count.
  always_ff @(posedge clk) begin
    // NOTE: the stack is left unreset; count gates every read, so stale
    // entries are never observed.
    if (state == DIVIDE) digit_buf[count] <= rem;
  end
`endif

  // Datapath and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      base      <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_digit <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cur   <= in_value;
            base  <= in_base;
            count <= '0;
            if (in_base < DIGIT_W'(2)) begin
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_last  <= 1'b1;
              out_digit <= '0;
            end
          end
        end
        DIVIDE: begin
          cur <= quo;
`ifdef RADIX_SERIALIZER_MSB_FIRST_EN
          if (quo == '0) begin
            // Top of stack goes straight to the output; count stays on it.
            out_digit <= rem;
            out_last  <= (count == '0);
            out_valid <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
`else
          out_digit <= rem;
          out_last  <= (quo == '0);
          out_valid <= 1'b1;
          count     <= count + 1'b1;
`endif
        end
        EMIT: begin
          if (out_ready) begin
`ifdef RADIX_SERIALIZER_MSB_FIRST_EN
            if (out_last) begin
              out_valid <= 1'b0;
            end else begin
              out_digit <= digit_buf[count - 1'b1];
              out_last  <= (count == CNT_W'(1));
              count     <= count - 1'b1;
            end
`else
            out_valid <= 1'b0;
`endif
          end
        end
        ERR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

  // Base is screened on accept, so the divider never sees a zero divisor,
  // and the digit index must stay inside the stack depth.
  assert property (@(posedge clk) disable iff (rst)
    (state == DIVIDE) |-> (!div_err && (int'(count) < MAX_DIGITS)));

endmodule
